// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback-stage arbiter that merges NUM_SRC execution-unit results
// into one register-file write port.
//
// Ports:
//   cpu_clk, cpu_rst       clock, synchronous active-high reset
//   src_valid/dst/data     per-source result, flattened (source i at slice i)
//   src_ready              one-hot grant; a transfer is src_valid[i] && src_ready[i]
//   wb_stall               register-file port busy: no grant, write enable low
//   fwd_en/fwd_dst/fwd_out combinational view of the result accepted this cycle
//   we/dst/out             registered register-file write, one cycle after acceptance
//   conflict_cnt           saturating count of cycles with two or more valid sources
//
// Handshake: a source holds valid/dst/data stable until the cycle in which its
// src_ready is high; that cycle is the transfer. src_ready is a function of
// src_valid, wb_stall, cpu_rst and the round-robin pointer only.
module wb_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int ARB_MODE   = 0,
    parameter int DISCARD_R0 = 0,
    parameter int CNT_W      = 8
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_dst,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      wb_stall,
    output logic                      fwd_en,
    output logic [REG_AW-1:0]         fwd_dst,
    output logic [DATA_W-1:0]         fwd_out,
    output logic                      we,
    output logic [REG_AW-1:0]         dst,
    output logic [DATA_W-1:0]         out,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               we_q, we_d;
    logic [REG_AW-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SRC-1:0] upper_valid;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] onehot;
    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [REG_AW-1:0]  win_dst;
    logic [DATA_W-1:0]  win_data;
    logic               xfer;
    logic               multi_valid;

    // Round-robin reduces to a lowest-index search over a candidate set: the
    // valid sources at or above rr_ptr if any exist, otherwise all valid
    // sources (the wrap-around half).
    always_comb begin
        upper_valid = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            upper_valid[i] = src_valid[i] && (PTR_W'(i) >= rr_ptr_q);
        end
        cand = (ARB_MODE == 1 && (|upper_valid)) ? upper_valid : src_valid;
    end

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        onehot   = '0;
        win_dst  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && cand[i]) begin
                found    = 1'b1;
                winner   = PTR_W'(i);
                onehot   = '0;
                onehot[i] = 1'b1;
                win_dst  = src_dst[i*REG_AW +: REG_AW];
                win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset and stall both block the grant, so fwd_en is already low in those
    // cycles and can drive the write-enable flop directly.
    always_comb begin
        xfer      = found && !cpu_rst && !wb_stall;
        src_ready = xfer ? onehot : '0;
        fwd_en    = xfer && ((DISCARD_R0 == 0) || (win_dst != '0));
        fwd_dst   = xfer ? win_dst : '0;
        fwd_out   = xfer ? win_data : '0;
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_valid = |(src_valid & (src_valid - NUM_SRC'(1)));

    always_comb begin
        we_d     = fwd_en;
        dst_d    = fwd_en ? fwd_dst : dst_q;
        out_d    = fwd_en ? fwd_out : out_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + PTR_W'(1);
        end
        cnt_d = cnt_q;
        if (!wb_stall && multi_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            dst_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            dst_q    <= dst_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
        end
    end

    assign we           = we_q;
    assign dst          = dst_q;
    assign out          = out_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two instances run side by side.
//   fx: NUM_SRC=2, fixed priority, R0 written normally, CNT_W=2
//   rr: NUM_SRC=3, round-robin, R0 discarded,         CNT_W=8
// Sources hold their result until granted; the reference model decides grants
// from the arbitration rules and tracks the registered stage and counter.
module tb_wb_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic cpu_clk = 1'b0;
    logic cpu_rst;
    logic wb_stall;

    always #5 cpu_clk = ~cpu_clk;

    logic [1:0]      a_valid, a_ready;
    logic [2*AW-1:0] a_dst;
    logic [2*DW-1:0] a_data;
    logic            a_fwd_en, a_we;
    logic [AW-1:0]   a_fwd_dst, a_wdst;
    logic [DW-1:0]   a_fwd_out, a_wout;
    logic [1:0]      a_cnt;

    logic [2:0]      b_valid, b_ready;
    logic [3*AW-1:0] b_dst;
    logic [3*DW-1:0] b_data;
    logic            b_fwd_en, b_we;
    logic [AW-1:0]   b_fwd_dst, b_wdst;
    logic [DW-1:0]   b_fwd_out, b_wout;
    logic [7:0]      b_cnt;

    wb_arbiter #(.NUM_SRC(2), .DATA_W(DW), .REG_AW(AW), .ARB_MODE(0), .DISCARD_R0(0), .CNT_W(2)) u_fx (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .src_valid(a_valid), .src_dst(a_dst),
        .src_data(a_data), .src_ready(a_ready), .wb_stall(wb_stall), .fwd_en(a_fwd_en),
        .fwd_dst(a_fwd_dst), .fwd_out(a_fwd_out), .we(a_we), .dst(a_wdst), .out(a_wout),
        .conflict_cnt(a_cnt)
    );

    wb_arbiter #(.NUM_SRC(3), .DATA_W(DW), .REG_AW(AW), .ARB_MODE(1), .DISCARD_R0(1), .CNT_W(8)) u_rr (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .src_valid(b_valid), .src_dst(b_dst),
        .src_data(b_data), .src_ready(b_ready), .wb_stall(wb_stall), .fwd_en(b_fwd_en),
        .fwd_dst(b_fwd_dst), .fwd_out(b_fwd_out), .we(b_we), .dst(b_wdst), .out(b_wout),
        .conflict_cnt(b_cnt)
    );

    // instance configuration, index 0 = fx, 1 = rr
    int cfg_n[2]    = '{2, 3};
    int cfg_mode[2] = '{0, 1};
    int cfg_disc[2] = '{0, 1};
    int cfg_max[2]  = '{3, 255};

    // source-side pending results
    bit s_v[2][3];
    int s_d[2][3];
    int s_x[2][3];

    // reference model state
    int m_we[2], m_dst[2], m_out[2], m_cnt[2], m_ptr[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int j = 0; j < 2; j++) begin
            a_valid[j]          = s_v[0][j];
            a_dst[j*AW +: AW]   = AW'(s_d[0][j]);
            a_data[j*DW +: DW]  = DW'(s_x[0][j]);
        end
        for (int j = 0; j < 3; j++) begin
            b_valid[j]          = s_v[1][j];
            b_dst[j*AW +: AW]   = AW'(s_d[1][j]);
            b_data[j*DW +: DW]  = DW'(s_x[1][j]);
        end
    endtask

    task automatic set_src(input int k, input int i, input int d, input int x);
        s_v[k][i] = 1'b1;
        s_d[k][i] = d;
        s_x[k][i] = x;
    endtask

    task automatic clear_src();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) s_v[k][i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_we[k] = 0; m_dst[k] = 0; m_out[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        end
    endtask

    // One clock: apply inputs at negedge, check all outputs just after, then
    // advance the model at the rising edge. A granted source re-presents a new
    // random result with probability refill_pct, otherwise goes idle.
    task automatic cycle(input bit rst, input bit stall, input int refill_pct);
        int  win[2];
        bit  fen[2];
        int  nv;
        string p;
        @(negedge cpu_clk);
        cpu_rst  = rst;
        wb_stall = stall;
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            win[k] = -1;
            if (!rst && !stall) begin
                for (int j = 0; j < cfg_n[k]; j++) begin
                    int idx;
                    idx = (cfg_mode[k] == 1) ? (m_ptr[k] + j) % cfg_n[k] : j;
                    if (win[k] < 0 && s_v[k][idx]) win[k] = idx;
                end
            end
            fen[k] = (win[k] >= 0) && !(cfg_disc[k] == 1 && s_d[k][win[k]] == 0);
            p = (k == 0) ? "fx" : "rr";
            check({p, "_ready"},   (k == 0) ? 32'(a_ready)   : 32'(b_ready),
                  (win[k] >= 0) ? (32'd1 << win[k]) : 32'd0);
            check({p, "_fwd_en"},  (k == 0) ? 32'(a_fwd_en)  : 32'(b_fwd_en), 32'(fen[k]));
            check({p, "_fwd_dst"}, (k == 0) ? 32'(a_fwd_dst) : 32'(b_fwd_dst),
                  (win[k] >= 0) ? 32'(s_d[k][win[k]]) : 32'd0);
            check({p, "_fwd_out"}, (k == 0) ? 32'(a_fwd_out) : 32'(b_fwd_out),
                  (win[k] >= 0) ? 32'(s_x[k][win[k]]) : 32'd0);
            check({p, "_we"},      (k == 0) ? 32'(a_we)      : 32'(b_we),      32'(m_we[k]));
            check({p, "_dst"},     (k == 0) ? 32'(a_wdst)    : 32'(b_wdst),    32'(m_dst[k]));
            check({p, "_out"},     (k == 0) ? 32'(a_wout)    : 32'(b_wout),    32'(m_out[k]));
            check({p, "_cnt"},     (k == 0) ? 32'(a_cnt)     : 32'(b_cnt),     32'(m_cnt[k]));
        end
        @(posedge cpu_clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_we[k] = 0; m_dst[k] = 0; m_out[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
            end else begin
                nv = 0;
                for (int j = 0; j < cfg_n[k]; j++) nv += int'(s_v[k][j]);
                if (!stall && nv >= 2 && m_cnt[k] < cfg_max[k]) m_cnt[k]++;
                m_we[k] = int'(fen[k]);
                if (fen[k]) begin
                    m_dst[k] = s_d[k][win[k]];
                    m_out[k] = s_x[k][win[k]];
                end
                if (win[k] >= 0) begin
                    m_ptr[k] = (win[k] + 1) % cfg_n[k];
                    if (int'($urandom_range(0, 99)) < refill_pct)
                        set_src(k, win[k], int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
                    else
                        s_v[k][win[k]] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        cpu_rst  = 1'b1;
        wb_stall = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge cpu_clk);
        model_reset();

        // reset holds grants off even with sources pending
        set_src(0, 0, 3, 'h1111);
        set_src(0, 1, 5, 'h2222);
        set_src(1, 2, 9, 'h3333);
        cycle(1, 0, 0);

        // fixed priority pair; rr instance has only src2 valid with rr_ptr=0
        repeat (3) cycle(0, 0, 0);

        // all three rr sources continuously valid: grants 0,1,2,0,1,2
        set_src(1, 0, 1, 'h0A01);
        set_src(1, 1, 2, 'h0A02);
        set_src(1, 2, 4, 'h0A03);
        repeat (6) cycle(0, 0, 100);
        clear_src();
        cycle(0, 0, 0);

        // stall for three cycles, then release
        set_src(0, 0, 7, 'hBEEF);
        set_src(1, 0, 7, 'hBEEF);
        repeat (3) cycle(0, 1, 0);
        repeat (2) cycle(0, 0, 0);

        // write to r0: discarded on rr, written on fx
        set_src(0, 1, 0, 'hAAAA);
        set_src(1, 1, 0, 'hAAAA);
        repeat (2) cycle(0, 0, 0);

        // counter saturation on the 2-bit fx counter: 1,2,3,3,3
        cycle(1, 0, 0);
        set_src(0, 0, 1, 'h0101);
        set_src(0, 1, 2, 'h0202);
        repeat (5) cycle(0, 0, 100);
        clear_src();

        // reset in the middle of traffic; first grant afterwards goes to src0
        for (int i = 0; i < 3; i++) set_src(1, i, i + 8, 'h5000 + i);
        set_src(0, 0, 12, 'h6000);
        set_src(0, 1, 13, 'h6001);
        repeat (3) cycle(0, 0, 100);
        for (int i = 0; i < 3; i++) set_src(1, i, i + 8, 'h5100 + i);
        cycle(1, 0, 100);
        repeat (2) cycle(0, 0, 0);
        clear_src();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < cfg_n[k]; i++)
                    if (!s_v[k][i] && $urandom_range(0, 1) == 1)
                        set_src(k, i, int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Parametrised writeback stage that merges results from NUM_SRC execution units (ALU, MAU, future units) into the single register-file write port. It arbitrates among simultaneously valid sources with a valid/ready handshake, so losing sources stall rather than drop data. It exposes a combinational forwarding view of the winning result and registers the result one cycle later for the register file. It also counts arbitration conflicts for performance monitoring.

Parameters:
NUM_SRC, 2, number of result sources (>=1)
DATA_W, 16, result data width
REG_AW, 4, register index width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
DISCARD_R0, 0, 1 = writes to register 0 are accepted but never written or forwarded
CNT_W, 8, width of the conflict counter

Ports:
cpu_clk  in  1  clock, all state updates on rising edge
cpu_rst  in  1  synchronous reset, active-high
src_valid  in  NUM_SRC  source i holds a result
src_dst  in  NUM_SRC*REG_AW  destination index, source i in slice [i*REG_AW +: REG_AW]
src_data  in  NUM_SRC*DATA_W  result data, source i in slice [i*DATA_W +: DATA_W]
src_ready  out  NUM_SRC  one-hot grant; transfer when src_valid[i] && src_ready[i]
wb_stall  in  1  register-file port unavailable this cycle
fwd_en  out  1  a result is being accepted this cycle (combinational)
fwd_dst  out  REG_AW  destination of the accepted result (combinational)
fwd_out  out  DATA_W  data of the accepted result (combinational)
we  out  1  registered register-file write enable
dst  out  REG_AW  registered write index
out  out  DATA_W  registered write data
conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (cpu_rst=1 at a clock edge): we=0, dst=0, out=0, conflict_cnt=0, rr_ptr=0. While cpu_rst=1, src_ready=0 and fwd_en=0. Reset overrides stall and all other inputs. Reset applied mid-transfer drops any result not yet accepted. Sources re-present it after reset.
- Grant (combinational): when cpu_rst=0, wb_stall=0 and any src_valid=1, exactly one src_ready bit is set. Otherwise src_ready=0.
- Fixed priority (ARB_MODE=0): the lowest-index valid source wins.
- Round-robin (ARB_MODE=1): the winner is the first valid source at index >= rr_ptr, wrapping modulo NUM_SRC.
- rr_ptr update: on a transfer, rr_ptr <= (winner+1) mod NUM_SRC. With no transfer, rr_ptr holds. In fixed-priority mode rr_ptr is unused.
- Source rules: a source keeps valid, dst and data stable until it is granted. The block does not check this rule; stability is the source's responsibility. src_ready never depends on the same source's dst or data.
- Forwarding:
  - fwd_en = transfer this cycle, and additionally (dst != 0) when DISCARD_R0=1.
  - fwd_dst and fwd_out carry the winner's slices when a source is granted, else 0. They are never X or Z.
  - A discarded R0 write still completes the handshake (src_ready=1) but sets fwd_en=0.
- Registered stage (1-cycle latency from acceptance to we):
  - If wb_stall=0: we <= fwd_en. When fwd_en=1, dst <= fwd_dst and out <= fwd_out. Otherwise dst and out hold.
  - If wb_stall=1: we <= 0; dst and out hold; no source is granted.
- Conflict counter: increments by 1 on each edge where cpu_rst=0, wb_stall=0 and at least two src_valid bits are set. It saturates at 2^CNT_W-1 (no wrap).
- NUM_SRC=1 degenerates to a pass-through with a register stage and handshake; conflict_cnt stays 0.
- Throughput: one accepted result per cycle, maximum. Back-to-back grants to the same source are allowed.

Test Plan:
- Fixed priority: NUM_SRC=2, ARB_MODE=0, src0=(r3,0x1111) and src1=(r5,0x2222) both valid, held until granted -> cycle0 ready=01, fwd 3/0x1111; cycle1 ready=10, we=1 dst=3 out=0x1111; cycle2 we=1 dst=5 out=0x2222; conflict_cnt=1.
- Round-robin: NUM_SRC=3, ARB_MODE=1, all three sources valid continuously -> grants cycle 0,1,2,0,1,2; in a cycle with only src2 valid and rr_ptr=0, src2 is granted and rr_ptr becomes 0.
- Stall: src0 valid with (r7,0xBEEF), wb_stall=1 for 3 cycles -> src_ready=0, fwd_en=0, we=0, dst/out hold previous values; stall drops -> grant next cycle, we=1 with r7/0xBEEF one cycle later.
- R0 discard: DISCARD_R0=1, src1 writes (r0,0xAAAA) -> src_ready[1]=1 and fwd_en=0; next cycle we=0 and dst/out unchanged. With DISCARD_R0=0 -> we=1, dst=0, out=0xAAAA.
- Reset mid-operation: after several writes, assert cpu_rst for 1 cycle with sources valid -> src_ready=0 during reset; after the edge we=0, dst=0, out=0, conflict_cnt=0, rr_ptr=0; the first post-reset grant goes to src0.
- Counter saturation: CNT_W=2, 5 conflict cycles -> conflict_cnt sequence 1,2,3,3,3.
